// File: rtl/bitbakery_serial_tx_sched_pkg.sv
// bitbakery_serial_tx_sched_pkg: shared constants, FSM states and packet field encodings
package bitbakery_serial_tx_sched_pkg;
  localparam logic [7:0] SOF_BYTE = 8'hA5;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;
  typedef enum logic [1:0] {F_SOF, F_HDR, F_PAY, F_CHK} field_t;
  function automatic logic [7:0] hdr_byte(input logic s, input logic [3:0] l);
    return {s, 3'b000, l};
  endfunction
endpackage

// File: rtl/bitbakery_serial_tx_sched_if.sv
// bitbakery_serial_tx_sched_if: requester and transmitter handshake bundle
interface bitbakery_serial_tx_sched_if;
  logic req_a, req_b;
  logic [3:0] len_a, len_b;
  logic [7:0] data_a, data_b;
  logic [3:0] idx;
  logic sel, done_a, done_b, busy;
  logic [7:0] tx_dados;
  logic tx_iniciar, tx_fim;
  modport master (
    output req_a, req_b, len_a, len_b, data_a, data_b, tx_fim,
    input  idx, sel, done_a, done_b, busy, tx_dados, tx_iniciar
  );
  modport slave (
    input  req_a, req_b, len_a, len_b, data_a, data_b, tx_fim,
    output idx, sel, done_a, done_b, busy, tx_dados, tx_iniciar
  );
endinterface

// File: rtl/bitbakery_serial_tx_sched_fd.sv
// bitbakery_serial_tx_sched_fd: packet datapath with byte mux, checksum, index and grant latches
module bitbakery_serial_tx_sched_fd
  import bitbakery_serial_tx_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       adv,
  input  logic       show,
  input  logic       gnt_sel,
  input  logic [3:0] gnt_len,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic [3:0] idx,
  output logic       sel,
  output logic       field_chk,
  output logic [7:0] tx_dados
);
  field_t field;
  logic [3:0] len;
  logic [7:0] chk, cur;
  logic last_pay;
  always_comb begin
    cur = field == F_SOF ? SOF_BYTE :
          field == F_HDR ? hdr_byte(sel, len) :
          field == F_PAY ? (sel ? data_b : data_a) : chk;
    last_pay = !(idx < len - 4'd1);
    tx_dados = show ? cur : 8'h00;
    field_chk = field == F_CHK;
  end
  always_ff @(posedge clock) begin
    if (reset || load) begin
      field <= F_SOF;
      len   <= reset ? 4'd0 : gnt_len;
      sel   <= reset ? 1'b0 : gnt_sel;
      idx   <= 4'd0;
      chk   <= 8'h00;
    end else if (adv) begin
      chk   <= (field == F_HDR || field == F_PAY) ? chk ^ cur : chk;
      field <= field == F_SOF ? F_HDR :
               field == F_HDR ? (len == 4'd0 ? F_CHK : F_PAY) :
               field == F_PAY ? (last_pay ? F_CHK : F_PAY) : F_CHK;
      idx   <= (field == F_PAY && !last_pay) ? idx + 4'd1 : idx;
    end
  end
endmodule

// File: rtl/bitbakery_serial_tx_sched.sv
// bitbakery_serial_tx_sched: round-robin two-requester packet scheduler feeding a byte transmitter
module bitbakery_serial_tx_sched
  import bitbakery_serial_tx_sched_pkg::*;
(
  input logic clock,
  input logic reset,
  bitbakery_serial_tx_sched_if.slave bus
);
  state_t state, state_nxt;
  logic last, gnt_sel, load, adv, show, field_chk, sel;
  logic [3:0] gnt_len, idx;
  logic [7:0] tx_dados;
  // on a tie the requester not served last wins; last resets to B so A wins first
  assign gnt_sel = (bus.req_a && bus.req_b) ? !last : bus.req_b;
  assign gnt_len = gnt_sel ? bus.len_b : bus.len_a;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == S_DONE) last <= sel;
    end
  end
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    adv = 1'b0;
    case (state)
      S_IDLE: begin
        load = bus.req_a || bus.req_b;
        state_nxt = load ? S_START : S_IDLE;
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = bus.tx_fim ? S_NEXT : S_WAIT;
      S_NEXT: begin
        adv = 1'b1;
        state_nxt = field_chk ? S_DONE : S_START;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  assign show = state == S_START || state == S_WAIT;
  bitbakery_serial_tx_sched_fd u_fd (
    .clock(clock), .reset(reset), .load(load), .adv(adv), .show(show),
    .gnt_sel(gnt_sel), .gnt_len(gnt_len), .data_a(bus.data_a), .data_b(bus.data_b),
    .idx(idx), .sel(sel), .field_chk(field_chk), .tx_dados(tx_dados)
  );
  assign bus.idx        = idx;
  assign bus.sel        = sel;
  assign bus.tx_dados   = tx_dados;
  assign bus.tx_iniciar = state == S_START;
  assign bus.busy       = state != S_IDLE;
  assign bus.done_a     = state == S_DONE && !sel;
  assign bus.done_b     = state == S_DONE && sel;
endmodule
